// File: rtl/peasant_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
// The digit-count helper gives ceil(bits/digit), the number of CALC steps for a multiplier.
package peasant_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int LEGAL_DIGIT_BITS [3] = '{1, 2, 4};

  function automatic bit legal_digit_bits(input int d);
    legal_digit_bits = 1'b0;
    for (int i = 0; i < 3; i++)
      if (LEGAL_DIGIT_BITS[i] == d) legal_digit_bits = 1'b1;
  endfunction

  function automatic int digit_count(input int nbits, input int digit);
    return (nbits + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/peasant_digit_pp.sv
// Partial product of one multiplier digit (DIGIT_BITS wide) against the shifted multiplicand.
module peasant_digit_pp
  import peasant_pkg::*;
#(
  parameter int NBITS      = 20,
  parameter int DIGIT_BITS = 1
) (
  input  logic [DIGIT_BITS-1:0] digit,
  input  logic [2*NBITS-1:0]    mcand,
  output logic [2*NBITS-1:0]    pp
);

  always_comb begin
    pp = '0;
    for (int i = 0; i < DIGIT_BITS; i++)
      if (digit[i]) pp = pp + (mcand << i);
  end

endmodule

// File: rtl/peasant_mul_sm.sv
// Sign-magnitude shift-and-add multiplier behind a valid/ready stream, retiring
// DIGIT_BITS multiplier bits per cycle and stopping once the multiplier is exhausted.
module peasant_mul_sm
  import peasant_pkg::*;
#(
  parameter int NBITS      = 20,
  parameter int DIGIT_BITS = 1,
  parameter int SWAP_EN    = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NBITS-1:0]   A,
  input  logic [NBITS-1:0]   B,
  input  logic               iSigned,
  input  logic               iValid,
  output logic               iReady,
  output logic               oValid,
  input  logic               oReady,
  output logic [2*NBITS-1:0] result
);

  localparam int W2 = 2 * NBITS;

  generate
    if (!legal_digit_bits(DIGIT_BITS)) begin : g_bad_digit_bits
      $error("peasant_mul_sm: DIGIT_BITS must be 1, 2 or 4");
    end
  endgenerate

  // -2^(NBITS-1) negates to itself, which read unsigned is exactly its magnitude.
  function automatic logic [NBITS-1:0] magnitude(input logic [NBITS-1:0] v, input logic is_signed);
    return (is_signed && v[NBITS-1]) ? -v : v;
  endfunction

  state_t           state, state_n;
  logic             ready_n, ovalid_n, neg, neg_n, swap;
  logic [W2-1:0]    result_n, acc, acc_n, mcand, mcand_n, pp;
  logic [NBITS-1:0] mplier, mplier_n, mag_a, mag_b;

  assign mag_a = magnitude(A, iSigned);
  assign mag_b = magnitude(B, iSigned);
  assign swap  = (SWAP_EN != 0) && (mag_a > mag_b);

  peasant_digit_pp #(
    .NBITS      (NBITS),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_digit_pp (
    .digit (mplier[DIGIT_BITS-1:0]),
    .mcand (mcand),
    .pp    (pp)
  );

  always_comb begin
    state_n  = state;
    ready_n  = iReady;
    ovalid_n = oValid;
    result_n = result;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    neg_n    = neg;
    case (state)
      IDLE: begin
        if (iValid && iReady) begin
          ready_n = 1'b0;
          state_n = CALC;
          neg_n   = iSigned & (A[NBITS-1] ^ B[NBITS-1]);
          acc_n   = '0;
          if (swap) begin
            mplier_n = mag_b;
            mcand_n  = {{NBITS{1'b0}}, mag_a};
          end else begin
            mplier_n = mag_a;
            mcand_n  = {{NBITS{1'b0}}, mag_b};
          end
        end else begin
          ready_n = 1'b1;
        end
      end
      CALC: begin
        if (mplier != '0) begin
          acc_n    = acc + pp;
          mplier_n = mplier >> DIGIT_BITS;
          mcand_n  = mcand << DIGIT_BITS;
        end else begin
          result_n = neg ? -acc : acc;
          ovalid_n = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (oReady) begin
          ovalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      iReady <= 1'b0;
      oValid <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      state  <= state_n;
      iReady <= ready_n;
      oValid <= ovalid_n;
      result <= result_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      neg    <= neg_n;
    end
  end

endmodule

// File: tb/tb_peasant_mul_sm.sv
// Scoreboard bench for peasant_mul_sm (NBITS=20, DIGIT_BITS=2, SWAP_EN=1): the driver
// queues hand-computed products and latencies, and a monitor pops them as results appear.
module tb_peasant_mul_sm;
  import peasant_pkg::*;

  localparam int NBITS      = 20;
  localparam int DIGIT_BITS = 2;
  localparam int SWAP_EN    = 1;
  localparam int W2         = 2 * NBITS;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NBITS-1:0] A = '0;
  logic [NBITS-1:0] B = '0;
  logic             iSigned = 1'b0;
  logic             iValid = 1'b0;
  logic             iReady;
  logic             oValid;
  logic             oReady = 1'b1;
  logic [W2-1:0]    result;

  peasant_mul_sm #(
    .NBITS      (NBITS),
    .DIGIT_BITS (DIGIT_BITS),
    .SWAP_EN    (SWAP_EN)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .iSigned (iSigned),
    .iValid  (iValid),
    .iReady  (iReady),
    .oValid  (oValid),
    .oReady  (oReady),
    .result  (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W2-1:0] res;
    int            lat;
    int            acc_cyc;
    string         name;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          prev_ov = 1'b0;
  logic [W2-1:0] held = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected latency: 1 + ceil(bitlen(multiplier magnitude) / DIGIT_BITS)
  function automatic int exp_latency(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                     input logic s);
    logic [NBITS-1:0] ma, mb, m;
    int n;
    ma = (s && a[NBITS-1]) ? -a : a;
    mb = (s && b[NBITS-1]) ? -b : b;
    m  = (SWAP_EN != 0 && ma > mb) ? mb : ma;
    n  = 0;
    for (int i = 0; i < NBITS; i++) if (m[i]) n = i + 1;
    return 1 + digit_count(n, DIGIT_BITS);
  endfunction

  function automatic logic [W2-1:0] ref_prod(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                             input logic s);
    logic signed [W2-1:0] sa, sbv;
    logic [W2-1:0] ua, ub;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {{NBITS{1'b0}}, a};
    ub  = {{NBITS{1'b0}}, b};
    return s ? W2'(sa * sbv) : ua * ub;
  endfunction

  task automatic chk(input string nm, input logic [W2-1:0] got, input logic [W2-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  // Monitor: handshake exclusivity every cycle, result/latency on oValid rise, hold while stalled
  always @(negedge clock) begin
    checks++;
    if (iReady && oValid) begin
      errors++;
      $display("FAIL ready_valid_overlap at cycle %0d: iReady=1 oValid=1, want not both", cyc);
    end
    if (oValid && !prev_ov) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ovalid at cycle %0d: result %h with no pending transaction", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (result !== mon_e.res) begin
          errors++;
          $display("FAIL %s result: got %h, want %h", mon_e.name, result, mon_e.res);
        end
        checks++;
        if (cyc - mon_e.acc_cyc != mon_e.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d, want %0d", mon_e.name, cyc - mon_e.acc_cyc, mon_e.lat);
        end
      end
      held = result;
    end else if (oValid && prev_ov) begin
      checks++;
      if (result !== held) begin
        errors++;
        $display("FAIL hold_stable at cycle %0d: got %h, want %h", cyc, result, held);
      end
    end
    prev_ov = oValid;
  end

  task automatic send(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input logic s,
                      input logic [W2-1:0] exp_res, input string nm);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clock);
    while (!iReady && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!iReady) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout: iReady stayed 0 for %0d cycles, want 1", nm, guard);
      return;
    end
    A = a;
    B = b;
    iSigned = s;
    iValid = 1'b1;
    @(posedge clock);
    #1;
    e.res = exp_res;
    e.lat = exp_latency(a, b, s);
    e.acc_cyc = cyc;
    e.name = nm;
    sb.push_back(e);
    // Garbage operands with iValid held high must be ignored outside IDLE
    A = ~a;
    B = a ^ b;
    iSigned = ~s;
    @(posedge clock);
    @(posedge clock);
    #1;
    iValid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || oValid) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0 || oValid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NBITS-1:0] ra, rb;
    logic             rs;
    int               guard;

    #1;
    chk("reset_iready", W2'(iReady), W2'(0));
    chk("reset_ovalid", W2'(oValid), W2'(0));
    chk("reset_result", result, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("release_iready", W2'(iReady), W2'(1));

    send(20'd13, 20'd11, 1'b0, 40'd143, "u13x11");
    send(20'hFFFF9, 20'd6, 1'b1, 40'hFF_FFFF_FFD6, "s_m7x6");
    send(20'h80000, 20'h80000, 1'b1, 40'h40_0000_0000, "s_min_sq");
    send(20'hFFFFF, 20'd3, 1'b0, 40'h2F_FFFD, "u_swap_max_x3");
    send(20'd0, 20'hFFFFF, 1'b0, 40'd0, "u_zero");
    send(20'hFFFFF, 20'd3, 1'b1, 40'hFF_FFFF_FFFD, "s_m1x3");
    send(20'd5, 20'hFFFFF, 1'b1, 40'hFF_FFFF_FFFB, "s_5xm1");
    send(20'hFFFFF, 20'hFFFFF, 1'b0, 40'hFF_FFE0_0001, "u_max_sq");
    send(20'h7FFFF, 20'h80000, 1'b1, 40'hC0_0008_0000, "s_maxpos_min");
    send(20'h80000, 20'd2, 1'b0, 40'h10_0000, "u_msb_x2");
    send(20'd0, 20'hFFFFB, 1'b1, 40'd0, "s_zero_neg");
    drain();

    // Backpressure: result must hold for 10 stalled cycles, then a single oReady pulse
    oReady = 1'b0;
    send(20'd100, 20'd200, 1'b0, 40'd20000, "bp_100x200");
    guard = 0;
    while (!oValid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("bp_ovalid_rise", W2'(oValid), W2'(1));
    repeat (10) @(negedge clock);
    chk("bp_ovalid_held", W2'(oValid), W2'(1));
    chk("bp_result_held", result, 40'd20000);
    oReady = 1'b1;
    @(negedge clock);
    chk("bp_ovalid_fall", W2'(oValid), W2'(0));
    chk("bp_iready_gap", W2'(iReady), W2'(0));
    chk("bp_result_kept", result, 40'd20000);
    @(negedge clock);
    chk("bp_iready_back", W2'(iReady), W2'(1));

    // Reset mid-CALC aborts the transaction with no result
    send(20'hFFFFF, 20'hFFFFF, 1'b0, 40'hFF_FFE0_0001, "rst_abort");
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_iready", W2'(iReady), W2'(0));
    chk("abort_ovalid", W2'(oValid), W2'(0));
    chk("abort_result", result, '0);
    void'(sb.pop_back());
    repeat (3) @(negedge clock);
    reset = 1'b1;
    send(20'd2, 20'd3, 1'b0, 40'd6, "post_reset_2x3");
    drain();

    for (int i = 0; i < 24; i++) begin
      ra = NBITS'($urandom);
      rb = NBITS'($urandom);
      if (i % 3 == 0) rb = NBITS'($urandom_range(0, 15));
      if (i % 5 == 0) ra = NBITS'($urandom_range(0, 3));
      rs = i[0];
      send(ra, rb, rs, ref_prod(ra, rb, rs), $sformatf("rand%0d", i));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
